code25_serial_receiver: RTL and testbench
=========================================

// Module: code25_serial_receiver
// PURPOSE
//  Serial front end for the 2-of-5 display path. Deserialises 5-bit 2-of-5
//  code words, MSB first, and checks each word has exactly two ones. The
//  last valid word is held on E1..E5, which drive the per-segment decoders
//  directly. Invalid or incomplete frames never reach the decoders.
// PARAMETERS
//  TIMEOUT  16  idle cycles allowed between bits inside a frame before abort (>=1)
//  ERR_W    4   width of saturating error counter
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_n       in   1      synchronous, active-low reset
//  serial_in   in   1      data bit, sampled only when bit_valid=1
//  bit_valid   in   1      serial_in is valid this cycle
//  frame_start in   1      qualifies bit_valid: this bit is bit 1 (E1) of a new frame
//  E1..E5      out  1 each held code word (E1 = first bit received)
//  word_valid  out  1      1-cycle pulse: E1..E5 just updated with a valid word
//  code_error  out  1      1-cycle pulse: complete frame with weight != 2 was discarded
//  timeout     out  1      1-cycle pulse: incomplete frame aborted
//  err_count   out  ERR_W  saturating count of code_error + timeout events
// BEHAVIOUR
//  - Reset (rst_n=0 at a rising edge): state=IDLE. E1..E5, word_valid, code_error,
//    timeout and err_count are all 0. Shift register, bit count and idle
//    counter are cleared. Reset mid-frame discards the partial frame.
//  - IDLE: bit_valid without frame_start is ignored.
//    bit_valid&frame_start: capture bit as bit 1, bitcnt=1, go to RECV.
//  - RECV: bit_valid&!frame_start: shift bit in and increment bitcnt.
//    Idle counter clears on every accepted bit.
//  - RECV: bit_valid&frame_start: restart. Partial frame dropped silently
//    (no error), bit captured as bit 1, bitcnt=1.
//  - 5th bit accepted at edge k: weight of the full 5-bit word is checked
//    combinationally and registered at that same edge k (latency 1 edge from
//    the 5th bit). State returns to IDLE.
//    - weight==2: E1..E5 <= word; word_valid=1 for one cycle.
//    - weight!=2: E1..E5 unchanged; code_error=1 for one cycle; err_count+1.
//  - RECV with no bit_valid for TIMEOUT consecutive cycles: timeout=1 for one
//    cycle, err_count+1, go to IDLE. E1..E5 unchanged.
//  - err_count saturates at 2^ERR_W-1. No wrap. Cleared only by reset.
//  - word_valid, code_error and timeout are mutually exclusive in any cycle.
//  - E1..E5 change only on a word_valid cycle, so they are always a legal
//    2-of-5 word or all zeros (post-reset).
// STRUCTURE
//  - Shared package code25_pkg: WORD_W=5, state encoding (IDLE, RECV), and
//    function is_2of5(word). The same constant/function is reused by encoders.
//  - One sub-module: code25_weight_check (5-bit in, ok out; popcount==2).
//    Purely combinational, shared with other 2-of-5 consumers.
//  - Top: FSM, 5-bit shift register, 3-bit bitcnt, idle counter of width
//    $clog2(TIMEOUT+1), output registers.
// TESTING
//  1. Reset, then send 1,1,0,0,0 with frame_start on bit 1 -> at edge after
//     bit 5: E1..E5=1,1,0,0,0, word_valid pulse, err_count=0.
//  2. Send 1,1,1,0,0 -> code_error pulse, E1..E5 keep previous value,
//     err_count=1, no word_valid.
//  3. Send 3 bits, then hold bit_valid=0 for 16 cycles -> timeout pulse on
//     the 16th idle cycle, err_count+1, next frame 0,0,0,1,1 accepted normally.
//  4. Send 2 bits, then frame_start with 0,1,1,0,0 -> E1..E5=0,1,1,0,0,
//     no error, no timeout.
//  5. Assert rst_n=0 after bit 3 of a frame -> all outputs 0. Later bits
//     4..5 without frame_start are ignored; no word_valid.
//  6. Send 17 invalid frames (ERR_W=4) -> err_count reaches 15 and stays 15.

Source files
------------

// File: rtl/code25_pkg.sv
// Shared 2-of-5 definitions: word width, receiver state encoding and the
// weight predicate used by both encoders and decoders.
package code25_pkg;

    localparam int WORD_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    // A legal 2-of-5 word has exactly two bits set.
    function automatic logic is_2of5(input logic [WORD_W-1:0] word);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < WORD_W; i++) begin
            ones += int'(word[i]);
        end
        return (ones == 2);
    endfunction

endpackage

// File: rtl/code25_weight_check.sv
// Combinational 2-of-5 weight checker: ok is high when exactly two bits are set.
module code25_weight_check
    import code25_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic              ok_o
);

    // Weight test shared with every other 2-of-5 consumer.
    always_comb begin
        ok_o = is_2of5(word_i);
    end

endmodule

// File: rtl/code25_serial_receiver.sv
// Serial 2-of-5 receiver: deserialises MSB-first 5-bit frames, forwards only
// legal words to E1..E5, and reports malformed or stalled frames.
module code25_serial_receiver
    import code25_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ERR_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic             E1,
    output logic             E2,
    output logic             E3,
    output logic             E4,
    output logic             E5,
    output logic             word_valid,
    output logic             code_error,
    output logic             timeout,
    output logic [ERR_W-1:0] err_count
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    rx_state_e         state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              wv_q, wv_d;
    logic              cerr_q, cerr_d;
    logic              tmo_q, tmo_d;
    logic [ERR_W-1:0]  errc_q, errc_d;

    // Candidate full word if the incoming bit completes the frame.
    logic [WORD_W-1:0] full_word;
    logic              full_ok;

    assign full_word = {sr_q[WORD_W-2:0], serial_in};

    code25_weight_check u_wchk (
        .word_i (full_word),
        .ok_o   (full_ok)
    );

    // Receive FSM: frame assembly, completion check and idle timeout.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bitcnt_d = bitcnt_q;
        idle_d   = idle_q;
        word_d   = word_q;
        wv_d     = 1'b0;
        cerr_d   = 1'b0;
        tmo_d    = 1'b0;
        errc_d   = errc_q;

        unique case (state_q)
            IDLE: begin
                if (bit_valid && frame_start) begin
                    sr_d     = {{(WORD_W-1){1'b0}}, serial_in};
                    bitcnt_d = 3'd1;
                    idle_d   = '0;
                    state_d  = RECV;
                end
            end
            RECV: begin
                if (bit_valid && frame_start) begin
                    // Restart drops the partial frame without flagging it.
                    sr_d     = {{(WORD_W-1){1'b0}}, serial_in};
                    bitcnt_d = 3'd1;
                    idle_d   = '0;
                end else if (bit_valid) begin
                    idle_d = '0;
                    if (bitcnt_q == 3'(WORD_W - 1)) begin
                        state_d  = IDLE;
                        sr_d     = '0;
                        bitcnt_d = '0;
                        if (full_ok) begin
                            word_d = full_word;
                            wv_d   = 1'b1;
                        end else begin
                            cerr_d = 1'b1;
                            if (errc_q != ERR_MAX) errc_d = errc_q + 1'b1;
                        end
                    end else begin
                        sr_d     = full_word;
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_d  = IDLE;
                    sr_d     = '0;
                    bitcnt_d = '0;
                    idle_d   = '0;
                    tmo_d    = 1'b1;
                    if (errc_q != ERR_MAX) errc_d = errc_q + 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            bitcnt_q <= '0;
            idle_q   <= '0;
            word_q   <= '0;
            wv_q     <= 1'b0;
            cerr_q   <= 1'b0;
            tmo_q    <= 1'b0;
            errc_q   <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bitcnt_q <= bitcnt_d;
            idle_q   <= idle_d;
            word_q   <= word_d;
            wv_q     <= wv_d;
            cerr_q   <= cerr_d;
            tmo_q    <= tmo_d;
            errc_q   <= errc_d;
        end
    end

    // First received bit lands in the MSB, so E1 is word[4].
    assign E1         = word_q[4];
    assign E2         = word_q[3];
    assign E3         = word_q[2];
    assign E4         = word_q[1];
    assign E5         = word_q[0];
    assign word_valid = wv_q;
    assign code_error = cerr_q;
    assign timeout    = tmo_q;
    assign err_count  = errc_q;

endmodule

// File: tb/tb_code25_serial_receiver.sv
// Directed bench for the 2-of-5 serial receiver.
module tb_code25_serial_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial_in;
    logic       bit_valid;
    logic       frame_start;
    logic       E1, E2, E3, E4, E5;
    logic       word_valid, code_error, timeout;
    logic [3:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;

    code25_serial_receiver #(.TIMEOUT(16), .ERR_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .E1          (E1),
        .E2          (E2),
        .E3          (E3),
        .E4          (E4),
        .E5          (E5),
        .word_valid  (word_valid),
        .code_error  (code_error),
        .timeout     (timeout),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic fs, input logic b);
        bit_valid   = 1'b1;
        frame_start = fs;
        serial_in   = b;
        tick();
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        serial_in   = 1'b0;
    endtask

    // Send a full frame, MSB (E1) first, frame_start on bit 1.
    task automatic send_frame(input logic [4:0] w);
        for (int i = 4; i >= 0; i--) send_bit(i == 4, w[i]);
    endtask

    function automatic logic [4:0] evec();
        return {E1, E2, E3, E4, E5};
    endfunction

    function automatic logic [2:0] flags();
        return {word_valid, code_error, timeout};
    endfunction

    initial begin
        rst_n = 1'b0; serial_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
        tick(); tick();
        chk("rst_E", 32'(evec()), 32'h0);
        chk("rst_flags", 32'(flags()), 32'h0);
        chk("rst_errc", 32'(err_count), 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: valid word 11000
        send_frame(5'b11000);
        chk("t1_E", 32'(evec()), 32'h18);
        chk("t1_flags", 32'(flags()), 32'h4);
        chk("t1_errc", 32'(err_count), 32'h0);
        tick();
        chk("t1_pulse_end", 32'(flags()), 32'h0);

        // 2: weight 3 rejected
        send_frame(5'b11100);
        chk("t2_E", 32'(evec()), 32'h18);
        chk("t2_flags", 32'(flags()), 32'h2);
        chk("t2_errc", 32'(err_count), 32'h1);
        tick();
        chk("t2_pulse_end", 32'(flags()), 32'h0);

        // 3: three bits then 16 idle cycles -> timeout
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        chk("t3_before_tmo", 32'(flags()), 32'h0);
        tick();
        chk("t3_tmo", 32'(flags()), 32'h1);
        chk("t3_errc", 32'(err_count), 32'h2);
        chk("t3_E", 32'(evec()), 32'h18);
        tick();
        chk("t3_pulse_end", 32'(flags()), 32'h0);
        send_frame(5'b00011);
        chk("t3_next_E", 32'(evec()), 32'h03);
        chk("t3_next_flags", 32'(flags()), 32'h4);

        // 4: partial frame restarted by frame_start
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_frame(5'b01100);
        chk("t4_E", 32'(evec()), 32'h0C);
        chk("t4_flags", 32'(flags()), 32'h4);
        chk("t4_errc", 32'(err_count), 32'h2);

        // 5: reset mid-frame; trailing bits ignored
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_rst_E", 32'(evec()), 32'h0);
        chk("t5_rst_flags", 32'(flags()), 32'h0);
        chk("t5_rst_errc", 32'(err_count), 32'h0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("t5_ignored_E", 32'(evec()), 32'h0);
        chk("t5_ignored_flags", 32'(flags()), 32'h0);
        for (int i = 0; i < 20; i++) tick();
        chk("t5_no_tmo", 32'(flags()), 32'h0);

        // 6: saturating error counter
        send_frame(5'b01010);
        for (int i = 0; i < 17; i++) begin
            send_frame((i % 2 == 0) ? 5'b11111 : 5'b00001);
            chk($sformatf("t6_cerr_%0d", i), 32'(flags()), 32'h2);
            chk($sformatf("t6_errc_%0d", i), 32'(err_count), (i < 15) ? 32'(i + 1) : 32'd15);
        end
        chk("t6_E_kept", 32'(evec()), 32'h0A);
        tick();
        chk("t6_errc_hold", 32'(err_count), 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1);
    end

endmodule
